// File: rtl/poly1305_mac_sequencer.sv
// Poly1305 MAC sequencer: walks 16-byte blocks through the shared multiplier and reducer,
// keeps the accumulator and clamped key, and produces the 128-bit tag.
module poly1305_mac_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [255:0]   otk,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic [127:0]   blk_data,
  input  logic [4:0]     blk_bytes,
  input  logic           blk_last,
  output logic           mul_start,
  output logic [129:0]   mul_a,
  output logic [127:0]   mul_b,
  input  logic           mul_done,
  output logic           red_start,
  input  logic [129:0]   red_out,
  input  logic           red_done,
  output logic           tag_valid,
  output logic [127:0]   tag,
  output logic           busy,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BLK = 3'd1,
    S_ADD      = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_RED_WAIT = 3'd4,
    S_FINAL    = 3'd5
  } state_e;

  localparam logic [129:0] P130  = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  // Block integer: keep the low n bytes and set the pad bit just above them.
  function automatic logic [128:0] block_int(input logic [127:0] d, input logic [4:0] n);
    logic [128:0] m;
    m = {1'b0, d};
    for (int i = 0; i < 16; i++) begin
      if (5'(i) >= n) m[8*i +: 8] = 8'h00;
    end
    m[{n, 3'b000}] = 1'b1;
    return m;
  endfunction

  state_e         state_q, state_d;
  logic [129:0]   acc_q, acc_d;
  logic [127:0]   r_q, r_d, s_q, s_d;
  logic [128:0]   m_q, m_d;
  logic           last_q, last_d;
  logic [129:0]   mul_a_q, mul_a_d;
  logic [127:0]   mul_b_q, mul_b_d;
  logic           mul_start_q, mul_start_d, red_start_q, red_start_d;
  logic           tag_valid_q, tag_valid_d, err_q, err_d;
  logic [127:0]   tag_q, tag_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic [130:0]   sum_s;
  logic           timeout_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 130'd0;
      r_q         <= 128'd0;
      s_q         <= 128'd0;
      m_q         <= 129'd0;
      last_q      <= 1'b0;
      mul_a_q     <= 130'd0;
      mul_b_q     <= 128'd0;
      mul_start_q <= 1'b0;
      red_start_q <= 1'b0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= 128'd0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      s_q         <= s_d;
      m_q         <= m_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      red_start_q <= red_start_d;
      tag_valid_q <= tag_valid_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
      wd_q        <= wd_d;
    end
  end

  assign sum_s     = {1'b0, acc_q} + {2'b00, m_q};
  assign timeout_s = (wd_q == CW'(TIMEOUT - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    r_d         = r_q;
    s_d         = s_q;
    m_d         = m_q;
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_d       = tag_q;
    wd_d        = wd_q;
    mul_start_d = 1'b0;
    red_start_d = 1'b0;
    tag_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = otk[127:0] & CLAMP;
          s_d     = otk[255:128];
          acc_d   = 130'd0;
          state_d = S_WAIT_BLK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_BLK: begin
        if (blk_valid) begin
          if ((blk_bytes == 5'd0) || (blk_bytes > 5'd16)) begin
            err_d = 1'b1;
          end else begin
            m_d     = block_int(blk_data, blk_bytes);
            last_d  = blk_last;
            state_d = S_ADD;
          end
        end else begin
          state_d = S_WAIT_BLK;
        end
      end
      S_ADD: begin
        // acc < p and m < 2^129, so one conditional subtraction fits in 130 bits.
        if (sum_s >= {1'b0, P130}) begin
          mul_a_d = sum_s[129:0] - P130;
        end else begin
          mul_a_d = sum_s[129:0];
        end
        mul_b_d     = r_q;
        mul_start_d = 1'b1;
        wd_d        = '0;
        state_d     = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          red_start_d = 1'b1;
          wd_d        = '0;
          state_d     = S_RED_WAIT;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      S_RED_WAIT: begin
        if (red_done) begin
          acc_d   = red_out;
          state_d = last_q ? S_FINAL : S_WAIT_BLK;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      S_FINAL: begin
        tag_d       = acc_q[127:0] + s_q;
        tag_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    blk_ready = (state_q == S_WAIT_BLK);
    busy      = (state_q != S_IDLE);
  end

  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign red_start = red_start_q;
  assign tag_valid = tag_valid_q;
  assign tag       = tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_poly1305_mac_sequencer.sv
// Bench for poly1305_mac_sequencer: behavioural mult/reduce responder, Poly1305 reference
// model and a tag scoreboard.
module tb_poly1305_mac_sequencer;

  localparam int TO = 16;
  localparam logic [259:0] P = (260'd1 << 130) - 260'd5;
  localparam logic [255:0] RFC_OTK = 256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] S2      = 128'h0102030405060708090a0b0c0d0e0f10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, blk_valid, blk_ready, blk_last;
  logic [255:0] otk;
  logic [127:0] blk_data, mul_b, tag;
  logic [4:0]   blk_bytes;
  logic         mul_start, mul_done, red_start, red_done, tag_valid, busy, err;
  logic [129:0] mul_a, red_out;

  poly1305_mac_sequencer #(.TIMEOUT(TO), .CW(11)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .otk(otk),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_bytes(blk_bytes), .blk_last(blk_last),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .red_start(red_start), .red_out(red_out), .red_done(red_done),
    .tag_valid(tag_valid), .tag(tag), .busy(busy), .err(err)
  );

  int tests = 0, fails = 0;
  logic [127:0] sb[$];
  logic [127:0] bd[4];
  int           bn[4];

  int cyc = 0, mul_seen = 0, red_seen = 0, err_cnt = 0, tv_cnt = 0, mul_cyc = 0, err_cyc = 0;
  int mlat = 0, rlat = 0, inj_req = 0, inj_ack = 0;
  bit mul_en = 1'b1, red_en = 1'b1;
  logic [129:0] cap_a = '0, prod_val = '0;
  logic [127:0] cap_b = '0;

  function automatic logic [129:0] mulmod(input logic [129:0] a, input logic [127:0] b);
    logic [259:0] x;
    x = {130'd0, a} * {132'd0, b};
    for (int k = 0; k < 3; k++) x = {130'd0, x[129:0]} + ({130'd0, x[259:130]} * 260'd5);
    for (int k = 0; k < 2; k++) if (x >= P) x = x - P;
    return x[129:0];
  endfunction

  function automatic logic [128:0] bint(input logic [127:0] d, input int nb);
    logic [128:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (i < nb) m[8*i +: 8] = d[8*i +: 8];
    m[8*nb] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] ref_tag(input logic [255:0] k, input int n);
    logic [129:0] acc;
    logic [259:0] t;
    logic [127:0] r;
    r   = k[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      t = {130'd0, acc} + {131'd0, bint(bd[i], bn[i])};
      if (t >= P) t = t - P;
      acc = mulmod(t[129:0], r);
    end
    return acc[127:0] + k[255:128];
  endfunction

  // Multiplier/reducer responder and event monitor, evaluated on every falling edge.
  initial begin
    mul_done = 1'b0; red_done = 1'b0; red_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mul_done = 1'b0;
      red_done = 1'b0;
      if (!reset_n) begin
        mlat = 0; rlat = 0;
      end else begin
        if (mlat > 0) begin mlat--; if (mlat == 0) mul_done = 1'b1; end
        if (rlat > 0) begin rlat--; if (rlat == 0) begin red_done = 1'b1; red_out = prod_val; end end
        if (inj_req != inj_ack) begin inj_ack = inj_req; red_done = 1'b1; red_out = 130'h123; end
      end
      if (mul_start) begin
        mul_seen++; mul_cyc = cyc; cap_a = mul_a; cap_b = mul_b;
        prod_val = mulmod(mul_a, mul_b);
        if (mul_en && reset_n) mlat = 3;
      end
      if (red_start) begin red_seen++; if (red_en && reset_n) rlat = 2; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (tag_valid) tv_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [255:0] k);
    otk = k; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d, input int n, input bit last);
    int w = 0;
    blk_valid = 1'b1; blk_data = d; blk_bytes = 5'(n); blk_last = last;
    while (!blk_ready && w < 1000) begin tick(); w++; end
    tests++;
    if (!blk_ready) begin fails++; $display("FAIL blk_ready_timeout: blk_ready=%0b required 1", blk_ready); end
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic run_msg(input logic [255:0] k, input int n, input bit with_start,
                         input bit inject, input string name);
    int tv0, m0, w;
    logic [127:0] exp_t;
    tv0 = tv_cnt;
    if (with_start) do_start(k);
    for (int i = 0; i < n; i++) begin
      m0 = mul_seen;
      send_blk(bd[i], bn[i], i == n - 1);
      if (inject && i == 0) begin
        w = 0;
        while (mul_seen == m0 && w < 200) begin tick(); w++; end
        otk = ~k; start = 1'b1;
        tick();
        start = 1'b0; otk = k;
      end
    end
    w = 0;
    while (tv_cnt == tv0 && w < 500) begin tick(); w++; end
    tests++;
    if (tv_cnt == tv0) begin
      fails++; $display("FAIL %s_no_tag: tag_valid count=%0d required %0d", name, tv_cnt, tv0 + 1);
    end else begin
      exp_t = sb.pop_front();
      if (tag !== exp_t) begin fails++; $display("FAIL %s_tag: got %h required %h", name, tag, exp_t); end
    end
    repeat (4) tick();
    tests++;
    if (tv_cnt !== tv0 + 1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_pulse: tag_valid pulses=%0d busy=%0b required 1 and 0", name, tv_cnt - tv0, busy);
    end
  endtask

  task automatic load_rfc();
    bd[0] = 128'h6f4620636968706172676f7470797243; bn[0] = 16;
    bd[1] = 128'h6f7247206863726165736552206d7572; bn[1] = 16;
    bd[2] = 128'hffffffffffffffffffffffffffff7075; bn[2] = 2;
  endtask

  task automatic test_reset();
    tests++;
    if ({blk_ready, mul_start, mul_a, mul_b, red_start, tag_valid, tag, busy, err} !== '0) begin
      fails++; $display("FAIL reset_outputs: tag=%h mul_a=%h busy=%0b required all 0", tag, mul_a, busy);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || blk_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%0b blk_ready=%0b required 0 0", busy, blk_ready);
    end
  endtask

  task automatic test_rfc(input string name);
    load_rfc();
    sb.push_back(RFC_TAG);
    run_msg(RFC_OTK, 3, 1'b1, 1'b0, name);
  endtask

  task automatic test_zero_r();
    bd[0] = '1; bn[0] = 16;
    sb.push_back(S2);
    run_msg({S2, 128'd0}, 1, 1'b1, 1'b0, "zero_r");
    tests++;
    if (cap_a !== {1'b0, {129{1'b1}}} || cap_b !== 128'd0) begin
      fails++; $display("FAIL zero_r_mul_ab: mul_a=%h mul_b=%h required %h 0", cap_a, cap_b, {1'b0, {129{1'b1}}});
    end
  endtask

  task automatic test_bad_bytes();
    int e0, m0;
    e0 = err_cnt; m0 = mul_seen;
    do_start(RFC_OTK);
    send_blk(128'h55, 0, 1'b1);
    send_blk(128'h55, 17, 1'b1);
    repeat (2) tick();
    tests++;
    if (err_cnt !== e0 + 2 || mul_seen !== m0 || blk_ready !== 1'b1) begin
      fails++; $display("FAIL bad_bytes: err pulses=%0d mul_starts=%0d blk_ready=%0b required 2 0 1",
                        err_cnt - e0, mul_seen - m0, blk_ready);
    end
    bd[0] = 128'hffffffffffffffffffffffffffffff00; bn[0] = 1;
    sb.push_back(ref_tag(RFC_OTK, 1));
    run_msg(RFC_OTK, 1, 1'b0, 1'b0, "one_byte");
  endtask

  task automatic test_timeout();
    int e0, tv0, w;
    logic [127:0] tag_b;
    mul_en = 1'b0;
    tag_b = tag; tv0 = tv_cnt; e0 = err_cnt;
    do_start(RFC_OTK);
    send_blk(128'h1234, 16, 1'b1);
    w = 0;
    while (err_cnt == e0 && w < 100) begin tick(); w++; end
    tests++;
    if (err_cnt == e0 || err_cyc - mul_cyc != TO) begin
      fails++; $display("FAIL timeout_latency: err after %0d cycles (seen=%0d) required %0d", err_cyc - mul_cyc, err_cnt - e0, TO);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || blk_ready !== 1'b0 || tag !== tag_b || tv_cnt !== tv0) begin
      fails++; $display("FAIL timeout_state: busy=%0b tag=%h tag_valid=%0d required 0 %h 0", busy, tag, tv_cnt - tv0, tag_b);
    end
    mul_en = 1'b1;
  endtask

  task automatic test_start_ignored();
    load_rfc();
    sb.push_back(RFC_TAG);
    run_msg(RFC_OTK, 3, 1'b1, 1'b1, "start_in_mul");
  endtask

  task automatic test_reset_mid();
    int r0, tv0, w;
    red_en = 1'b0;
    tv0 = tv_cnt; r0 = red_seen;
    load_rfc();
    do_start(RFC_OTK);
    send_blk(bd[0], 16, 1'b0);
    w = 0;
    while (red_seen == r0 && w < 100) begin tick(); w++; end
    repeat (3) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: busy=%0b required 1", busy); end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({blk_ready, mul_start, mul_a, mul_b, red_start, tag_valid, tag, busy, err} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: tag=%h mul_a=%h busy=%0b required all 0", tag, mul_a, busy);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    inj_req++;
    repeat (5) tick();
    tests++;
    if (busy !== 1'b0 || tv_cnt !== tv0 || tag !== 128'd0 || mul_a !== 130'd0) begin
      fails++; $display("FAIL post_reset_done: busy=%0b tag_valid=%0d tag=%h required 0 0 0", busy, tv_cnt - tv0, tag);
    end
    red_en = 1'b1;
    test_rfc("rfc_after_reset");
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; otk = '0;
    blk_valid = 1'b0; blk_data = '0; blk_bytes = 5'd0; blk_last = 1'b0;
    repeat (3) tick();
    test_reset();
    test_rfc("rfc");
    test_zero_r();
    test_bad_bytes();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
